// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg
// Shared constants for the program-counter sequencer and its stack-depth monitor:
// datapath widths, the reset and interrupt vectors, the control-op encoding and
// the sequencer state encoding.
package pc_ctrl_pkg;

   localparam int PC_W    = 11;                 // program counter / stack data width
   localparam int DEPTH   = 16;                 // hardware stack entries
   localparam int DEPTH_W = $clog2(DEPTH + 1);  // holds 0..DEPTH inclusive

   localparam logic [PC_W-1:0] RESET_VEC = 11'h000;
   localparam logic [PC_W-1:0] INT_VEC   = 11'h004;

   // Control-op encoding from the instruction decoder; 6 and 7 behave as SEQ.
   localparam logic [2:0] OP_SEQ    = 3'd0;
   localparam logic [2:0] OP_GOTO   = 3'd1;
   localparam logic [2:0] OP_CALL   = 3'd2;
   localparam logic [2:0] OP_RETURN = 3'd3;
   localparam logic [2:0] OP_RETFIE = 3'd4;
   localparam logic [2:0] OP_SKIP   = 3'd5;

   // Sequencer state encoding.
   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

endpackage

// File: rtl/stk_depth_mon.sv
// stk_depth_mon
// Shadows the occupancy of the hardware call stack from the push/pop strobes the
// sequencer sends it, and records sticky overflow / underflow events.
//
// Ports:
//   clk     in   clock, rising edge
//   reset   in   synchronous, active-high
//   push    in   stack push strobe (never asserted together with pop)
//   pop     in   stack pop strobe
//   depth   out  entries in use, 0..DEPTH
//   stk_ovf out  sticky: a push was issued while the stack was full
//   stk_unf out  sticky: a pop was issued while the stack was empty
module stk_depth_mon
   import pc_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic               pop,
   output logic [DEPTH_W-1:0] depth,
   output logic               stk_ovf,
   output logic               stk_unf
);

   localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(DEPTH);

   logic [DEPTH_W-1:0] depth_q;
   logic               ovf_q;
   logic               unf_q;

   // The stack itself wraps on overflow and keeps reading on underflow, so the
   // count saturates at both ends and only the sticky flags record the event.
   always_ff @(posedge clk) begin
      if (reset) begin
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else if (push) begin
         if (depth_q == FULL) ovf_q   <= 1'b1;
         else                 depth_q <= depth_q + 1'b1;
      end else if (pop) begin
         if (depth_q == '0)   unf_q   <= 1'b1;
         else                 depth_q <= depth_q - 1'b1;
      end
   end

   assign depth   = depth_q;
   assign stk_ovf = ovf_q;
   assign stk_unf = unf_q;

endmodule

// File: rtl/pc_stack_ctrl.sv
// pc_stack_ctrl
// Program-counter sequencer and initiator side of the 16 x 11-bit hardware call
// stack. Decodes SEQ/GOTO/CALL/RETURN/RETFIE/SKIP and the interrupt request,
// produces the next PC, the stack push/pop strobes with return-address data, and
// a one-cycle pipeline flush after every taken control transfer.
//
// Stack interface: push, pop and stack_in are combinational from the registered
// state and this cycle's inputs. The stack acts on them at the same rising edge
// that advances the PC; there is no back-pressure, the stack always accepts.
// push and pop are mutually exclusive, and both are forced low while stalled,
// while flushing, and during reset.
//
// Ports:
//   clk, reset   clock (rising edge), synchronous active-high reset
//   stall        freeze everything; no strobes
//   instr_valid  op/target are meaningful this cycle
//   op           control op (see pc_ctrl_pkg)
//   target       GOTO/CALL destination
//   skip_cond    SKIP is taken when 1
//   int_req      level interrupt request, honoured only when gie=1
//   stack_out    current top-of-stack value
//   pc           address of the instruction being executed
//   push, pop    stack strobes; stack_in is the data pushed
//   flush        fetched instruction is discarded (mirrors the FLUSH state)
//   gie          global interrupt enable
//   depth        stack entries in use; stk_ovf/stk_unf sticky error flags
module pc_stack_ctrl
   import pc_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               instr_valid,
   input  logic [2:0]         op,
   input  logic [PC_W-1:0]    target,
   input  logic               skip_cond,
   input  logic               int_req,
   input  logic [PC_W-1:0]    stack_out,
   output logic [PC_W-1:0]    pc,
   output logic               push,
   output logic               pop,
   output logic [PC_W-1:0]    stack_in,
   output logic               flush,
   output logic               gie,
   output logic [DEPTH_W-1:0] depth,
   output logic               stk_ovf,
   output logic               stk_unf
);

   logic [0:0]      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            gie_q, gie_d;
   logic            push_c, pop_c;
   logic [PC_W-1:0] stack_in_c;
   logic [PC_W-1:0] pc_plus1, pc_plus2;

   // Unsized wrap-around is intended: PC arithmetic is modulo 2^PC_W.
   assign pc_plus1 = pc_q + PC_W'(1);
   assign pc_plus2 = pc_q + PC_W'(2);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      gie_d      = gie_q;
      push_c     = 1'b0;
      pop_c      = 1'b0;
      stack_in_c = '0;

      // Reset is gated in here too so no strobe reaches the stack in the reset
      // cycle, keeping it consistent with its own pointer reset.
      if (!reset && !stall) begin
         if (state_q == ST_FLUSH) begin
            state_d = ST_RUN;
         end else if (int_req && gie_q) begin
            // Push the current pc, not pc+1: the interrupted instruction has
            // not executed yet and is re-run after RETFIE.
            push_c     = 1'b1;
            stack_in_c = pc_q;
            pc_d       = INT_VEC;
            gie_d      = 1'b0;
            state_d    = ST_FLUSH;
         end else if (instr_valid) begin
            unique case (op)
               OP_GOTO: begin
                  pc_d    = target;
                  state_d = ST_FLUSH;
               end
               OP_CALL: begin
                  push_c     = 1'b1;
                  stack_in_c = pc_plus1;
                  pc_d       = target;
                  state_d    = ST_FLUSH;
               end
               OP_RETURN: begin
                  pop_c   = 1'b1;
                  pc_d    = stack_out;
                  state_d = ST_FLUSH;
               end
               OP_RETFIE: begin
                  pop_c   = 1'b1;
                  pc_d    = stack_out;
                  gie_d   = 1'b1;
                  state_d = ST_FLUSH;
               end
               OP_SKIP: begin
                  if (skip_cond) begin
                     pc_d    = pc_plus2;
                     state_d = ST_FLUSH;
                  end else begin
                     pc_d = pc_plus1;
                  end
               end
               default: pc_d = pc_plus1;  // SEQ and the unused encodings
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_VEC;
         gie_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         gie_q   <= gie_d;
      end
   end

   stk_depth_mon u_depth_mon (
      .clk     (clk),
      .reset   (reset),
      .push    (push_c),
      .pop     (pop_c),
      .depth   (depth),
      .stk_ovf (stk_ovf),
      .stk_unf (stk_unf)
   );

   assign pc       = pc_q;
   assign push     = push_c;
   assign pop      = pop_c;
   assign stack_in = stack_in_c;
   assign flush    = (state_q == ST_FLUSH);
   assign gie      = gie_q;

endmodule
